xorshift128_share_ctrl: RTL

//  Sequences and shares one free-running xorshift128 generator among N_REQ clients.

---
 rtl/rng_ctrl_pkg.sv | 24 ++
 rtl/rr_arbiter_n.sv | 39 +++
 rtl/xorshift128_share_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/rng_ctrl_pkg.sv
// Shared types and constants for the xorshift128 sharing controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rng_ctrl_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned WARM_W = 8;

    localparam logic [DATA_W-1:0] DEFAULT_SEED_C = 32'h1234_5678;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_WARM  = 2'd1,
        ST_SERVE = 2'd2
    } state_e;

    // An all-zero seed would lock the generator at zero, so substitute the default.
    function automatic logic [DATA_W-1:0] fix_seed(input logic [DATA_W-1:0] seed,
                                                   input logic [DATA_W-1:0] dflt);
        return (seed == '0) ? dflt : seed;
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Round-robin pick: first asserted request at or after the pointer, wrapping at N.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is used.
module rr_arbiter_n #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             vld_o
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] k;

    // Scan N positions starting at the pointer; the first hit wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        sum   = '0;
        k     = '0;
        for (int i = 0; i < int'(N); i++) begin
            sum = {1'b0, ptr_i} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(N)) begin
                sum = sum - (IDX_W+1)'(N);
            end
            k = sum[IDX_W-1:0];
            if (!vld_o && req_i[k]) begin
                vld_o    = 1'b1;
                idx_o    = k;
                gnt_o[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xorshift128_share_ctrl.sv
// Seeds, warms up and shares one free-running xorshift128 among N_REQ clients.
// Latency: req sampled at edge k -> one-hot rsp_valid_o and rsp_data_o in cycle k+1.
// Backpressure: none; requests outside SERVE are ignored and unclaimed words are dropped.
module xorshift128_share_ctrl
    import rng_ctrl_pkg::*;
#(
    parameter int unsigned       N_REQ        = 4,
    parameter int unsigned       WARMUP_CYC   = 0,
    parameter logic [DATA_W-1:0] DEFAULT_SEED = DEFAULT_SEED_C
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req_i,
    output logic [N_REQ-1:0]  rsp_valid_o,
    output logic [DATA_W-1:0] rsp_data_o,
    input  logic              reseed_req_i,
    input  logic [DATA_W-1:0] reseed_seed_i,
    output logic              reseed_ack_o,
    output logic              ready_o,
    output logic [CNT_W-1:0]  words_served_o,
    output logic [DATA_W-1:0] gen_seed_o,
    output logic              gen_re_seed_o,
    input  logic [DATA_W-1:0] gen_rnd_i
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam logic [WARM_W-1:0] WARM_LAST =
        (WARMUP_CYC == 0) ? '0 : WARM_W'(WARMUP_CYC - 1);

    state_e             state_q, state_d;
    logic               armed_q;
    logic [DATA_W-1:0]  seed_q, seed_d;
    logic [WARM_W-1:0]  warm_cnt_q, warm_cnt_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic               ack_q, ack_d;
    logic [CNT_W-1:0]   words_q, words_d;

    logic               grant_en;
    logic               accept;
    logic               grant;
    logic [N_REQ-1:0]   arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_vld;

    rr_arbiter_n #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .vld_o (arb_vld)
    );

    // State register; reset lands in LOAD so the generator is always auto-seeded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Holds the first LOAD cycle after reset so gen_re_seed stays low while reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
        end
    end

    // Next-state: LOAD for one seeding cycle, WARM to discard outputs, SERVE until reseed.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_LOAD:  if (armed_q)                  state_d = ST_WARM;
            ST_WARM:  if (warm_cnt_q == WARM_LAST)  state_d = ST_SERVE;
            ST_SERVE: if (reseed_req_i)             state_d = ST_LOAD;
            default:                                state_d = ST_LOAD;
        endcase
    end

    // State-decoded outputs: seed strobe, ready, and whether this cycle may grant.
    always_comb begin
        gen_re_seed_o = 1'b0;
        ready_o       = 1'b0;
        grant_en      = 1'b0;
        accept        = 1'b0;
        unique case (state_q)
            ST_LOAD:  gen_re_seed_o = armed_q;
            ST_WARM:  ;
            ST_SERVE: begin
                ready_o  = 1'b1;
                accept   = reseed_req_i;
                grant_en = !reseed_req_i;
            end
            default:  ;
        endcase
    end

    assign grant = grant_en && arb_vld;

    // Datapath next values: seed capture, warm-up count, grant bookkeeping.
    always_comb begin
        seed_d      = seed_q;
        warm_cnt_d  = '0;
        ptr_d       = ptr_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        words_d     = words_q;
        ack_d       = (state_q == ST_WARM) && (state_d == ST_SERVE);

        if (accept) begin
            seed_d  = fix_seed(reseed_seed_i, DEFAULT_SEED);
            words_d = '0;
        end
        if (state_q == ST_LOAD) begin
            words_d = '0;
        end
        if (state_q == ST_WARM) begin
            warm_cnt_d = warm_cnt_q + WARM_W'(1);
        end
        if (grant) begin
            rsp_valid_d = arb_gnt;
            rsp_data_d  = gen_rnd_i;
            ptr_d       = (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
            if (words_q != '1) begin
                words_d = words_q + CNT_W'(1);
            end
        end
    end

    // Datapath registers; an in-flight response is discarded by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seed_q      <= DEFAULT_SEED;
            warm_cnt_q  <= '0;
            ptr_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            ack_q       <= 1'b0;
            words_q     <= '0;
        end else begin
            seed_q      <= seed_d;
            warm_cnt_q  <= warm_cnt_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            ack_q       <= ack_d;
            words_q     <= words_d;
        end
    end

    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_data_o     = rsp_data_q;
    assign reseed_ack_o   = ack_q;
    assign words_served_o = words_q;
    assign gen_seed_o     = seed_q;

endmodule
